// File: rtl/instruction_loader.sv
// instruction_loader: streams words from a ready/valid source into consecutive MMIO word indices
// Ports:
//   clock, reset                   positive-edge clock, synchronous active-high reset
//   start, base_index, word_count  load command, sampled in IDLE only
//   abort                          cancels a load in FETCH/WRITE
//   word_valid, word_data, word_ready           instruction word stream
//   write_req, write_index, write_data, write_ack  MMIO write port
//   busy, done, words_written      status
module instruction_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [INDEX_WIDTH-1:0] base_index,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   word_valid,
  input  logic [DATA_WIDTH-1:0]  word_data,
  output logic                   word_ready,
  output logic                   write_req,
  output logic [INDEX_WIDTH-1:0] write_index,
  output logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   write_ack,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_written
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] base_q, base_d, index_q, index_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, offset_q, offset_d, written_q, written_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   last;
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    offset_d  = offset_q;
    written_d = written_q;
    index_d   = index_q;
    data_d    = data_q;
    last      = (offset_q + COUNT_WIDTH'(1)) == count_q;
    case (state_q)
      IDLE: if (start) begin
        base_d    = base_index;
        count_d   = word_count;
        offset_d  = '0;
        written_d = '0;
        state_d   = (word_count == '0) ? DONE : FETCH;
      end
      FETCH: if (abort) state_d = IDLE;
        else if (word_valid) begin
          data_d  = word_data;
          index_d = base_q + INDEX_WIDTH'(offset_q);
          state_d = WRITE;
        end
      WRITE: begin
        // an ack coinciding with abort still counts the word
        if (write_ack) begin
          offset_d  = offset_q + COUNT_WIDTH'(1);
          written_d = written_q + COUNT_WIDTH'(1);
        end
        state_d = abort ? IDLE : !write_ack ? WRITE : last ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      count_q   <= '0;
      offset_q  <= '0;
      written_q <= '0;
      index_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      offset_q  <= offset_d;
      written_q <= written_d;
      index_q   <= index_d;
      data_q    <= data_d;
    end
  end
  assign word_ready    = state_q == FETCH;
  assign write_req     = state_q == WRITE;
  assign busy          = word_ready || write_req;
  assign done          = state_q == DONE;
  assign write_index   = index_q;
  assign write_data    = data_q;
  assign words_written = written_q;
endmodule
